// File: rtl/cam_eth_pingpong_scheduler_pkg.sv
// Shared encodings for the camera/Ethernet ping-pong bank scheduler.
// Bank lifecycle, writer and sender-side scheduler states.
package cam_eth_pingpong_scheduler_pkg;

  localparam int DEF_FRAME_SIZE = 1400;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_READY   = 2'd2,
    BANK_SENDING = 2'd3
  } bank_st_e;

  typedef enum logic {
    W_RUN   = 1'b0,
    W_STALL = 1'b1
  } wr_st_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } sch_st_e;

endpackage

// File: rtl/cam_eth_pingpong_scheduler_bank_writer.sv
// Camera-side bank writer: offset counter, bank close, stall and drops.
// Closes a bank on full or frame end and hops to the other bank when free.
module cam_bank_writer
  import cam_eth_pingpong_scheduler_pkg::*;
#(
  parameter int FRAME_SIZE = DEF_FRAME_SIZE,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pix_valid,
  input  logic [7:0]        i_cam_data,
  input  logic              i_frame_done,
  input  logic [1:0]        i_avail,
  output logic              o_fill,
  output logic              o_close,
  output logic              o_bank,
  output logic [ADDR_W-1:0] o_close_len,
  output logic              o_close_last,
  output logic              o_wr_en,
  output logic [ADDR_W:0]   o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_overflow,
  output logic [15:0]       o_drop_cnt
);

  wr_st_e            r_st;
  logic              r_wb;
  logic              r_pend;
  logic [ADDR_W-1:0] r_offset;
  logic              r_wr_en;
  logic [ADDR_W:0]   r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_ovf;
  logic [15:0]       r_drop;

  logic              w_accept;
  logic              w_full;
  logic              w_fdc;
  logic              w_nb;
  logic [ADDR_W-1:0] w_inc;

  always_comb begin
    w_accept = (r_st == W_RUN) && i_pix_valid;
    w_inc    = r_offset + 1'b1;
    w_full   = w_accept && (w_inc == ADDR_W'(FRAME_SIZE));
    w_fdc    = (r_st == W_RUN) && i_frame_done &&
               (w_accept || (r_offset != '0));
    w_nb     = ~r_wb;
  end

  assign o_fill       = w_accept && (r_offset == '0);
  assign o_close      = w_full || w_fdc;
  assign o_bank       = r_wb;
  assign o_close_len  = w_accept ? w_inc : r_offset;
  // A zero-length frame end is carried into the next bank that closes.
  assign o_close_last = r_pend || i_frame_done;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_overflow   = r_ovf;
  assign o_drop_cnt   = r_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st      <= W_RUN;
      r_wb      <= 1'b0;
      r_pend    <= 1'b0;
      r_offset  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ovf     <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= {r_wb, r_offset};
        r_wr_data <= i_cam_data;
      end
      unique case (r_st)
        W_RUN: begin
          if (o_close) begin
            r_offset <= '0;
            r_wb     <= w_nb;
            r_pend   <= 1'b0;
            r_st     <= i_avail[w_nb] ? W_RUN : W_STALL;
          end else if (w_accept) begin
            r_offset <= w_inc;
          end else if (i_frame_done) begin
            r_pend <= 1'b1;
          end
        end
        W_STALL: begin
          if (i_frame_done) r_pend <= 1'b1;
          if (i_avail[r_wb]) r_st <= W_RUN;
          if (i_pix_valid) begin
            r_ovf <= 1'b1;
            if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
          end
        end
        default: r_st <= W_RUN;
      endcase
    end
  end

endmodule

// File: rtl/cam_eth_pingpong_scheduler.sv
// Two-bank packet RAM sequencer between camera writer and Ethernet sender.
// Holds per-bank state and issues closed banks to the sender in order.
module cam_eth_pingpong_scheduler
  import cam_eth_pingpong_scheduler_pkg::*;
#(
  parameter int FRAME_SIZE = DEF_FRAME_SIZE,
  parameter int ADDR_W     = 11,
  parameter int SEQ_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [7:0]        cam_data,
  input  logic              frame_done,
  input  logic              eth_finish,
  output logic              ram_wr_en,
  output logic [ADDR_W:0]   ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  output logic              eth_start,
  output logic              eth_bank,
  output logic [ADDR_W-1:0] eth_len,
  output logic              eth_last,
  output logic [SEQ_W-1:0]  eth_seq,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  bank_st_e          r_bst  [2];
  logic [ADDR_W-1:0] r_blen [2];
  logic [1:0]        r_blast;
  sch_st_e           r_sst;
  logic              r_nxt;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_eth_start;
  logic              r_eth_bank;
  logic [ADDR_W-1:0] r_eth_len;
  logic              r_eth_last;
  logic [SEQ_W-1:0]  r_eth_seq;

  logic              w_fill;
  logic              w_close;
  logic              w_cbank;
  logic [ADDR_W-1:0] w_clen;
  logic              w_clast;
  logic [1:0]        w_avail;
  logic              w_fin;
  logic              w_cnxt;
  logic              w_issue;
  logic [ADDR_W-1:0] w_ilen;
  logic              w_ilast;

  cam_bank_writer #(
    .FRAME_SIZE(FRAME_SIZE),
    .ADDR_W    (ADDR_W)
  ) u_writer (
    .clk         (clk),
    .reset       (reset),
    .i_pix_valid (pix_valid),
    .i_cam_data  (cam_data),
    .i_frame_done(frame_done),
    .i_avail     (w_avail),
    .o_fill      (w_fill),
    .o_close     (w_close),
    .o_bank      (w_cbank),
    .o_close_len (w_clen),
    .o_close_last(w_clast),
    .o_wr_en     (ram_wr_en),
    .o_wr_addr   (ram_wr_addr),
    .o_wr_data   (ram_wr_data),
    .o_overflow  (overflow),
    .o_drop_cnt  (drop_cnt)
  );

  // A bank finishing this cycle counts as free so the writer never idles.
  always_comb begin
    w_fin      = (r_sst == S_BUSY) && eth_finish;
    w_avail[0] = (r_bst[0] == BANK_FREE) ||
                 ((r_bst[0] == BANK_SENDING) && w_fin);
    w_avail[1] = (r_bst[1] == BANK_FREE) ||
                 ((r_bst[1] == BANK_SENDING) && w_fin);
    w_cnxt     = w_close && (w_cbank == r_nxt);
    w_issue    = ((r_sst == S_IDLE) || w_fin) &&
                 ((r_bst[r_nxt] == BANK_READY) || w_cnxt);
    w_ilen     = w_cnxt ? w_clen  : r_blen[r_nxt];
    w_ilast    = w_cnxt ? w_clast : r_blast[r_nxt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        r_bst[b]  <= BANK_FREE;
        r_blen[b] <= '0;
      end
      r_blast <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_issue && (r_nxt == 1'(b))) begin
          r_bst[b] <= BANK_SENDING;
        end else if (w_close && (w_cbank == 1'(b))) begin
          r_bst[b]   <= BANK_READY;
          r_blen[b]  <= w_clen;
          r_blast[b] <= w_clast;
        end else if (w_fill && (w_cbank == 1'(b))) begin
          r_bst[b] <= BANK_FILLING;
        end else if (w_fin && (r_bst[b] == BANK_SENDING)) begin
          r_bst[b] <= BANK_FREE;
        end
      end
    end
  end

  // Banks close alternately, so a toggling pointer keeps close order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sst       <= S_IDLE;
      r_nxt       <= 1'b0;
      r_seq       <= '0;
      r_eth_start <= 1'b0;
      r_eth_bank  <= 1'b0;
      r_eth_len   <= '0;
      r_eth_last  <= 1'b0;
      r_eth_seq   <= '0;
    end else begin
      r_eth_start <= w_issue;
      if (w_issue) begin
        r_eth_bank <= r_nxt;
        r_eth_len  <= w_ilen;
        r_eth_last <= w_ilast;
        r_eth_seq  <= r_seq;
        r_seq      <= r_seq + 1'b1;
        r_nxt      <= ~r_nxt;
        r_sst      <= S_BUSY;
      end else if (w_fin) begin
        r_sst <= S_IDLE;
      end
    end
  end

  assign eth_start = r_eth_start;
  assign eth_bank  = r_eth_bank;
  assign eth_len   = r_eth_len;
  assign eth_last  = r_eth_last;
  assign eth_seq   = r_eth_seq;

endmodule
